// File: rtl/spiflash_resp_pkg.sv
// Shared definitions for the SPI flash read responder: FSM encodings, opcodes
// and the address-window test.
package spiflash_resp_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_ID     = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDID = 8'h9F;

  // True when the 24-bit flash address hits the 1 MiB window and lies in the backed range.
  function automatic logic in_window(input logic [23:0] a, input logic [3:0] base,
                                     input int unsigned size);
    return (a[23:20] == base) && ({12'd0, a[19:0]} < size);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous SPI line, with single-cycle
// rise/fall pulses derived from the synchronised level.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spiflash_resp.sv
// SPI flash responder serving READ (0x03) from a byte memory and RDID (0x9F);
// data bytes are prefetched one byte ahead so the serial stream never stalls.
module spiflash_resp
  import spiflash_resp_pkg::*;
#(
  parameter logic [3:0]  BASE_ADDR_M = 4'h1,
  parameter int unsigned SIZE_BYTES  = 8192,
  parameter int          MEM_AW      = 13,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              spi_csb,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso_do,
  output logic              spi_miso_oe,
  output logic              mem_re,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic csb_q, csb_rise, csb_fall;
  logic unused_sync;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .clk(clk), .resetn(resetn), .d_i(spi_clk),
    .q_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_csb (
    .clk(clk), .resetn(resetn), .d_i(spi_csb),
    .q_o(csb_q), .rise_o(csb_rise), .fall_o(csb_fall)
  );

  assign unused_sync = sclk_lvl ^ csb_rise;

  logic mosi_meta_q, mosi_q;
  logic [1:0]  warm_q;
  logic        armed_q;
  logic [2:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [23:0] addr_q, addr_d;
  logic [31:0] id_q, id_d;
  logic [7:0]  byte_q;
  logic        do_q, do_d;
  logic        mem_re_q, rd_pend_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic        fetch, win;
  logic [23:0] fetch_addr;

  assign win = in_window(fetch_addr, BASE_ADDR_M, SIZE_BYTES);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    id_d       = id_q;
    do_d       = do_q;
    fetch      = 1'b0;
    fetch_addr = addr_q + 24'd1;
    if (csb_q) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      do_d    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (csb_fall && armed_q) begin
          state_d = ST_CMD;
          cnt_d   = '0;
        end
        ST_CMD: if (sclk_rise) begin
          cmd_d = {cmd_q[6:0], mosi_q};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d = '0;
            if (cmd_d == CMD_READ) state_d = ST_ADDR;
            else if (cmd_d == CMD_RDID) begin
              state_d = ST_ID;
              id_d    = {JEDEC_ID, 8'hFF};
            end else state_d = ST_IGNORE;
          end
        end
        ST_ADDR: if (sclk_rise) begin
          addr_d = {addr_q[22:0], mosi_q};
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd23) begin
            cnt_d      = '0;
            state_d    = ST_DATA;
            fetch      = 1'b1;
            fetch_addr = addr_d;
          end
        end
        ST_DATA: if (sclk_fall) begin
          do_d  = byte_q[~cnt_q[2:0]];
          cnt_d = cnt_q + 5'd1;
          // Last bit of the byte is now on the wire, so the buffer is free for the next one.
          if (cnt_q == 5'd7) begin
            cnt_d  = '0;
            addr_d = addr_q + 24'd1;
            fetch  = 1'b1;
          end
        end
        ST_ID: if (sclk_fall) begin
          do_d = id_q[31];
          id_d = {id_q[30:0], 1'b1};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mosi_meta_q <= 1'b0;
      mosi_q      <= 1'b0;
      warm_q      <= '0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      id_q        <= '0;
      byte_q      <= '0;
      do_q        <= 1'b1;
      mem_re_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      mosi_meta_q <= spi_mosi;
      mosi_q      <= mosi_meta_q;
      // Only a csb-high level seen after the synchronisers refill may arm frame detection.
      warm_q      <= {warm_q[0], 1'b1};
      armed_q     <= armed_q | (warm_q[1] & csb_q);
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      id_q        <= id_d;
      do_q        <= do_d;
      mem_re_q    <= fetch & win;
      rd_pend_q   <= mem_re_q;
      if (fetch && win) mem_addr_q <= fetch_addr[MEM_AW-1:0];
      if (rd_pend_q) byte_q <= mem_rdata;
      else if (fetch && !win) byte_q <= 8'hFF;
    end
  end

  assign spi_miso_oe = (state_q == ST_DATA) || (state_q == ST_ID);
  assign spi_miso_do = spi_miso_oe ? do_q : 1'b1;
  assign mem_re      = mem_re_q;
  assign mem_addr    = mem_addr_q;
  assign busy        = ~csb_q;

endmodule

// File: tb/tb_spiflash_resp.sv
// Directed bench for spiflash_resp: table of SPI transactions plus abort and reset sequences.
module tb_spiflash_resp;

  localparam int H = 6;

  logic        clk = 1'b0;
  logic        resetn;
  logic        spi_csb, spi_clk, spi_mosi;
  logic        spi_miso_do, spi_miso_oe, mem_re, busy;
  logic [12:0] mem_addr;
  logic [7:0]  mem_rdata;

  always #5 clk = ~clk;

  spiflash_resp dut (
    .clk(clk), .resetn(resetn), .spi_csb(spi_csb), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso_do(spi_miso_do), .spi_miso_oe(spi_miso_oe),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy)
  );

  logic [7:0] mem [8192];
  initial for (int i = 0; i < 8192; i++) mem[i] = i[7:0];

  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

  int re_cnt = 0;
  int oe_cnt = 0;
  int bad_do = 0;
  always @(posedge clk) if (mem_re === 1'b1) re_cnt++;
  always @(negedge clk) begin
    if (spi_miso_oe === 1'b1) oe_cnt++;
    if (spi_miso_oe !== 1'b1 && spi_miso_do !== 1'b1) bad_do++;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    else n_pass++;
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sbit(input logic b, output logic s);
    spi_clk  = 1'b0;
    spi_mosi = b;
    wclk(H);
    s = spi_miso_do;
    spi_clk = 1'b1;
    wclk(H);
  endtask

  task automatic send(input logic [23:0] v, input int nb);
    logic s;
    for (int i = nb - 1; i >= 0; i--) sbit(v[i], s);
  endtask

  task automatic finish_frame();
    wclk(H);
    spi_csb = 1'b1;
    wclk(4);
    spi_clk = 1'b0;
    wclk(2 * H);
  endtask

  logic [7:0] got [8];

  task automatic xfer(input logic [7:0] cmd, input logic [23:0] addr, input bit has_addr,
                      input int n);
    logic s;
    spi_csb = 1'b0;
    wclk(H);
    send({16'd0, cmd}, 8);
    chk("busy_in_frame", busy, 1'b1);
    if (has_addr) send(addr, 24);
    for (int b = 0; b < n; b++) begin
      got[b] = 8'h00;
      for (int i = 0; i < 8; i++) begin
        sbit(1'b0, s);
        got[b] = {got[b][6:0], s};
      end
    end
    finish_frame();
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    bit          has_addr;
    int          n;
    logic [39:0] exp;
    int          re_lo;
    int          re_hi;
    bit          oe_exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int re0, oe0;
    logic [39:0] e;
    logic s;

    vecs[0] = '{8'h03, 24'h100010, 1'b1, 4, 40'h10_11_12_13_00, 4, 5, 1'b1};
    vecs[1] = '{8'h9F, 24'h000000, 1'b0, 5, 40'hEF_40_16_FF_FF, 0, 0, 1'b1};
    vecs[2] = '{8'h03, 24'h101FFF, 1'b1, 2, 40'hFF_FF_00_00_00, 1, 1, 1'b1};
    vecs[3] = '{8'h03, 24'h200000, 1'b1, 3, 40'hFF_FF_FF_00_00, 0, 0, 1'b1};
    vecs[4] = '{8'h05, 24'h000000, 1'b0, 2, 40'hFF_FF_00_00_00, 0, 0, 1'b0};
    vecs[5] = '{8'h03, 24'h1000FE, 1'b1, 3, 40'hFE_FF_00_00_00, 3, 4, 1'b1};
    vecs[6] = '{8'h03, 24'h0FFFFF, 1'b1, 2, 40'hFF_00_00_00_00, 1, 2, 1'b1};

    resetn   = 1'b0;
    spi_csb  = 1'b1;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    wclk(2);
    chk("rst_oe", spi_miso_oe, 1'b0);
    chk("rst_do", spi_miso_do, 1'b1);
    chk("rst_mem_re", mem_re, 1'b0);
    chk("rst_mem_addr", mem_addr, 13'd0);
    chk("rst_busy", busy, 1'b0);
    resetn = 1'b1;
    wclk(6);

    for (int v = 0; v < 7; v++) begin
      re0 = re_cnt;
      oe0 = oe_cnt;
      xfer(vecs[v].cmd, vecs[v].addr, vecs[v].has_addr, vecs[v].n);
      e = vecs[v].exp;
      for (int b = 0; b < vecs[v].n; b++)
        chk($sformatf("v%0d_byte%0d", v, b), got[b], e[39 - 8*b -: 8]);
      chk_rng($sformatf("v%0d_mem_re_count", v), re_cnt - re0, vecs[v].re_lo, vecs[v].re_hi);
      chk($sformatf("v%0d_oe_seen", v), (oe_cnt != oe0), vecs[v].oe_exp);
      chk($sformatf("v%0d_busy_after", v), busy, 1'b0);
    end

    // Frame aborted after 12 address bits must not disturb the next one.
    spi_csb = 1'b0;
    wclk(H);
    send(24'h000003, 8);
    send(24'h000FFF, 12);
    finish_frame();
    re0 = re_cnt;
    xfer(8'h03, 24'h100000, 1'b1, 1);
    chk("abort_next_byte", got[0], 8'h00);
    chk_rng("abort_next_mem_re", re_cnt - re0, 1, 2);

    // Reset in the middle of a data byte, with csb still low afterwards.
    spi_csb = 1'b0;
    wclk(H);
    send(24'h000003, 8);
    send(24'h100010, 24);
    for (int i = 0; i < 3; i++) sbit(1'b0, s);
    spi_clk = 1'b0;
    wclk(4);
    chk("pre_rst_oe", spi_miso_oe, 1'b1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_oe", spi_miso_oe, 1'b0);
    chk("mid_rst_mem_re", mem_re, 1'b0);
    chk("mid_rst_do", spi_miso_do, 1'b1);
    wclk(2);
    resetn = 1'b1;
    re0 = re_cnt;
    oe0 = oe_cnt;
    send(24'h0000A5, 8);
    chk("post_rst_oe_quiet", oe_cnt - oe0, 0);
    chk("post_rst_mem_re_quiet", re_cnt - re0, 0);
    finish_frame();
    xfer(8'h03, 24'h100020, 1'b1, 2);
    chk("post_rst_byte0", got[0], 8'h20);
    chk("post_rst_byte1", got[1], 8'h21);

    chk("do_high_when_not_driving", bad_do, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
